// File: rtl/ps2mouse_pkg.sv
// Shared field positions and widths for the PS/2 mouse cursor tracker.
package ps2mouse_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  localparam int ST_LSB  = 0;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 16;
  localparam int WHL_LSB = 24;
  localparam int WHL_W   = 4;

  localparam int DELTA_W = 9;
  localparam int POS_W   = 10;
  localparam int CALC_W  = 12;

  function automatic logic signed [7:0] sextWheel(input logic [WHL_W-1:0] w);
    return {{(8 - WHL_W){w[WHL_W-1]}}, w};
  endfunction

endpackage

// File: rtl/ps2mouse_axis_clamp.sv
// Adds a signed delta to an unsigned axis position and clamps the sum to [0, MAX].
// Purely combinational, no backpressure.
module ps2mouse_axis_clamp
  import ps2mouse_pkg::*;
#(
  parameter int MAX = 639
) (
  input  logic [POS_W-1:0]         iPos,
  input  logic signed [CALC_W-1:0] iDelta,
  output logic [POS_W-1:0]         oPos
);

  localparam logic signed [CALC_W-1:0] MAX_C = CALC_W'(MAX);

  logic signed [CALC_W-1:0] sum;

  always_comb begin
    sum = $signed({{(CALC_W - POS_W){1'b0}}, iPos}) + iDelta;
    if (sum[CALC_W-1])
      oPos = '0;
    else if (sum > MAX_C)
      oPos = MAX_C[POS_W-1:0];
    else
      oPos = sum[POS_W-1:0];
  end

endmodule

// File: rtl/ps2mouse_cursor_tracker.sv
// Validates PS/2 mouse packets and tracks a clamped cursor, saturating wheel and buttons.
// 3-cycle latency, one packet per cycle, no backpressure (packets are never stalled).
module ps2mouse_cursor_tracker
  import ps2mouse_pkg::*;
#(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int SHIFT  = 0
) (
  input  logic        CLOCK,
  input  logic        RST,
  input  logic        iTrig,
  input  logic [31:0] iData,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [2:0]  oBtn,
  output logic [2:0]  oPress,
  output logic [7:0]  oWheel,
  output logic        oTrig,
  output logic [7:0]  oErrCnt
);

  logic        s1Vld;
  logic [27:0] s1Dat;
  logic [7:0]  s1St;

  logic                      s2Vld;
  logic signed [DELTA_W-1:0] s2Dx, s2Dy;
  logic signed [7:0]         s2Wheel;
  logic [2:0]                s2Btn;

  logic signed [DELTA_W-1:0] rawDx, rawDy;
  logic signed [CALC_W-1:0]  dxWide, dyNeg;
  logic [POS_W-1:0]          nextX, nextY;
  logic [8:0]                wheelSum;
  logic [7:0]                nextWheel;

  // The ignored top nibble and the already-checked sync bit are deliberately dropped.
  logic unusedBits;
  assign unusedBits = ^{iData[31:28], s1Dat[ST_LSB + SYNC]};

  assign s1St = s1Dat[ST_LSB +: 8];

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      s1Vld   <= 1'b0;
      oErrCnt <= '0;
    end else begin
      s1Vld <= iTrig & iData[ST_LSB + SYNC];
      if (iTrig && !iData[ST_LSB + SYNC] && oErrCnt != 8'hFF)
        oErrCnt <= oErrCnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (iTrig)
      s1Dat <= iData[27:0];
  end

  always_comb begin
    rawDx = s1St[XO] ? '0 : {s1St[XS], s1Dat[X_LSB +: 8]};
    rawDy = s1St[YO] ? '0 : {s1St[YS], s1Dat[Y_LSB +: 8]};
  end

  always_ff @(posedge CLOCK) begin
    if (RST)
      s2Vld <= 1'b0;
    else
      s2Vld <= s1Vld;
  end

  always_ff @(posedge CLOCK) begin
    if (s1Vld) begin
      s2Dx    <= rawDx >>> SHIFT;
      s2Dy    <= rawDy >>> SHIFT;
      s2Wheel <= sextWheel(s1Dat[WHL_LSB +: WHL_W]);
      s2Btn   <= s1St[BTN_M:BTN_L];
    end
  end

  // Y grows downward on screen while the mouse reports up as positive.
  assign dxWide = {{(CALC_W - DELTA_W){s2Dx[DELTA_W-1]}}, s2Dx};
  assign dyNeg  = -{{(CALC_W - DELTA_W){s2Dy[DELTA_W-1]}}, s2Dy};

  ps2mouse_axis_clamp #(.MAX(X_MAX)) uClampX (
    .iPos  (oX),
    .iDelta(dxWide),
    .oPos  (nextX)
  );

  ps2mouse_axis_clamp #(.MAX(Y_MAX)) uClampY (
    .iPos  (oY),
    .iDelta(dyNeg),
    .oPos  (nextY)
  );

  always_comb begin
    wheelSum = {oWheel[7], oWheel} + {s2Wheel[7], s2Wheel};
    if (wheelSum[8] != wheelSum[7])
      nextWheel = wheelSum[8] ? 8'h80 : 8'h7F;
    else
      nextWheel = wheelSum[7:0];
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      oX     <= POS_W'(X_INIT);
      oY     <= POS_W'(Y_INIT);
      oBtn   <= '0;
      oPress <= '0;
      oWheel <= '0;
      oTrig  <= 1'b0;
    end else begin
      oTrig  <= s2Vld;
      oPress <= '0;
      if (s2Vld) begin
        oX     <= nextX;
        oY     <= nextY;
        oWheel <= nextWheel;
        oBtn   <= s2Btn;
        oPress <= s2Btn & ~oBtn;
      end
    end
  end

endmodule

// File: doc/ps2mouse_cursor_tracker.md
Name: ps2mouse_cursor_tracker

Overview:
- Sits directly downstream of the PS/2 mouse base module and consumes its one-cycle oTrig pulse and 32-bit packed packet word.
- Validates each packet, scales and accumulates the X/Y movement into a clamped screen cursor position, and accumulates the wheel into a saturating counter.
- Registers button state and produces button-press pulses.
- Feeds VGA overlay / application logic with a stable cursor position and a one-cycle update strobe.

Parameters:
- X_MAX, 639, max cursor X (inclusive); min is 0
- Y_MAX, 479, max cursor Y (inclusive); min is 0
- X_INIT, 320, cursor X after reset
- Y_INIT, 240, cursor Y after reset
- SHIFT, 0, arithmetic right-shift applied to each delta (sensitivity divider); legal range 0..3

Ports:
- CLOCK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous reset, active-high
- iTrig  in  1  one-cycle packet-valid pulse from the PS/2 mouse base module
- iData  in  32  packet: [7:0] status, [15:8] X byte, [23:16] Y byte, [27:24] wheel (4-bit signed), [31:28] ignored
- oX  out  10  cursor X, 0..X_MAX
- oY  out  10  cursor Y, 0..Y_MAX (screen convention: down is positive)
- oBtn  out  3  {middle, right, left} current button state
- oPress  out  3  one-cycle pulse per button on 0->1 transition
- oWheel  out  8  signed wheel accumulator, saturating at -128..+127
- oTrig  out  1  one-cycle pulse: outputs were updated this cycle
- oErrCnt  out  8  count of rejected packets, saturating at 255

Behaviour:
- Reset values (RST high at a rising edge):
  - oX=X_INIT, oY=Y_INIT
  - oBtn=0, oPress=0, oWheel=0, oTrig=0, oErrCnt=0
  - all pipeline valid bits cleared, so in-flight packets are discarded
- Pipeline: 3 stages, accepts one packet every cycle, no backpressure.
  - S1 (capture/validate):
    - On iTrig, check status[3]; it must be 1.
    - If status[3]=0: packet dropped, oErrCnt++ (saturating), no oTrig for this packet.
    - Otherwise latch iData and set S1 valid.
  - S2 (delta formation):
    - dx = signed 9-bit {status[4], X}; dy = signed 9-bit {status[5], Y}.
    - If status[6] (X overflow) is set, dx=0; if status[7] (Y overflow) is set, dy=0. Buttons and wheel still apply.
    - Both deltas arithmetic-shifted right by SHIFT (rounds toward minus infinity, so -1>>1 = -1).
    - Wheel sign-extended to 8 bits.
  - S3 (commit):
    - Compute nx = oX + dx and ny = oY - dy in 12-bit signed.
    - Clamp: <0 -> 0; >X_MAX -> X_MAX (likewise Y_MAX).
    - Register results into oX/oY.
    - oWheel += wheel, saturating at -128 and +127.
    - oBtn <= status[2:0]; oPress <= status[2:0] & ~oBtn(old).
    - oTrig=1 for exactly this cycle.
- Latency: iTrig sampled at edge t -> outputs updated and oTrig high in the cycle following edge t+2 (3 cycles after the iTrig cycle).
- oPress is high only in cycles where oTrig is high.
- Back-to-back iTrig on consecutive cycles: every valid packet commits in order on consecutive cycles.
  - No hazard: only S3 reads and writes the position, using the current registered oX/oY.
- Outputs hold between commits. oX/oY never leave [0, MAX] in any cycle.
- Reset asserted mid-packet: pipeline flushed; no oTrig for flushed packets.

Decomposition:
- Shared package ps2mouse_pkg:
  - status bit indices: BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7
  - iData field offsets
  - DELTA_W=9, POS_W=10, CALC_W=12
- One sub-module, ps2mouse_axis_clamp: combinational signed add and clamp to [0, MAX] with parameter MAX. Instantiated twice in S3 (Y with negated delta).

Test Plan:
- Reset, then packet status=0x08, X=0x05, Y=0x03 -> oTrig 3 cycles later; oX=325, oY=237; oBtn=0; oErrCnt=0.
- Packet status=0x18, X=0x80 (dx=-128), repeated 3 times from X=320 -> oX=192, 64, then 0 (clamped); oY unchanged.
- Packet status=0x09, then status=0x0B on the next cycle -> first commit: oPress=001, oBtn=001; second commit (next cycle): oPress=010, oBtn=011; oTrig high two consecutive cycles.
- Packet status=0x00 -> no oTrig, oErrCnt=1; 256 such packets -> oErrCnt holds 255.
- SHIFT=1, status=0x48 (X overflow), X=0x10, Y=0x08 -> oX unchanged, oY=Y_INIT-4. Then status=0x18, X=0xFF -> dx=-1 after shift, so oX decrements by 1.
- Wheel = 0x7 for 20 packets -> oWheel saturates at 127. Assert RST one cycle after an iTrig -> no oTrig; oX=320, oY=240, oWheel=0.
